// File: rtl/matrix_pkg.sv
// Shared types for the LED-matrix serial capture path.
// A captured word is {row index, column byte}; the row index is the
// position of the highest set bit of the received row pattern.
package matrix_pkg;

   localparam int MAT_N = 8;

   typedef logic [MAT_N-1:0]         mat_word_t;
   typedef logic [$clog2(MAT_N)-1:0] mat_idx_t;

   typedef struct packed {
      mat_idx_t  row;
      mat_word_t col;
   } mat_entry_t;

   // Index of the highest set bit; an all-zero pattern decodes to row 0.
   function automatic mat_idx_t mat_row_index(input mat_word_t w);
      mat_idx_t idx;
      idx = '0;
      for (int i = 0; i < MAT_N; i++) begin
         if (w[i]) idx = mat_idx_t'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with rising-edge detect, W bits wide.
// q is the second synchronizer stage; rise flags a 0->1 transition of q
// against its value one clk earlier.
module sync_edge #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic [W-1:0] rise
);

   logic [W-1:0] s1_q, s1_d;
   logic [W-1:0] s2_q, s2_d;
   logic [W-1:0] prev_q, prev_d;

   // Next-state for the synchronizer chain and the edge-history flop.
   always_comb begin
      s1_d   = d;
      s2_d   = s1_q;
      prev_d = s2_q;
   end

   // Synchronizer and history registers, cleared by the asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_q   <= '0;
         s2_q   <= '0;
         prev_q <= '0;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         prev_q <= prev_d;
      end
   end

   assign q    = s2_q;
   assign rise = s2_q & ~prev_q;

endmodule

// File: rtl/matrix_shift_capture.sv
// Receive-side capture of the serial 8x8 LED-matrix link.
// sck/scoldata/srowdata are synchronized into clk, every N sck rising edges
// form one {row index, column byte} word, and words leave through a
// valid/ready FIFO of DEPTH entries. A transfer that stalls for IDLE_CYCLES
// clk cycles is discarded silently.
// Optional build macro: ONEHOT_CHECK_EN -- adds a sticky row_err flag set when
// a completed row pattern is not one-hot; without it row_err is tied low.
// N must equal matrix_pkg::MAT_N since FIFO entries use the package types.
module matrix_shift_capture
   import matrix_pkg::*;
#(
   parameter int N           = MAT_N,
   parameter int DEPTH       = 4,
   parameter int IDLE_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 sck,
   input  logic                 scoldata,
   input  logic                 srowdata,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [$clog2(N)-1:0] out_row,
   output logic [N-1:0]         out_col,
   output logic                 overflow,
   output logic                 row_err
);

   localparam int RW = $clog2(N);
   localparam int PW = $clog2(DEPTH);
   localparam int IW = $clog2(IDLE_CYCLES + 1);

   // Synchronized inputs. Data comes from the same stage as sck so all three
   // lines see identical delay and data is stable when the edge is seen.
   logic       sck_level_unused;
   logic       sck_rise;
   logic [1:0] data_s;
   logic [1:0] data_rise_unused;

   sync_edge #(.W(1)) u_sck_sync (
      .clk   (clk),
      .reset (reset),
      .d     (sck),
      .q     (sck_level_unused),
      .rise  (sck_rise)
   );

   sync_edge #(.W(2)) u_data_sync (
      .clk   (clk),
      .reset (reset),
      .d     ({scoldata, srowdata}),
      .q     (data_s),
      .rise  (data_rise_unused)
   );

   logic [N-1:0]  col_sr_q, col_sr_d;
   logic [N-1:0]  row_sr_q, row_sr_d;
   logic [RW-1:0] bit_cnt_q, bit_cnt_d;
   logic [IW-1:0] idle_cnt_q, idle_cnt_d;
   logic          done;

   logic [PW:0]   wr_ptr_q, wr_ptr_d;
   logic [PW:0]   rd_ptr_q, rd_ptr_d;
   logic          overflow_q, overflow_d;
   mat_entry_t    fifo_mem [DEPTH];
   mat_entry_t    push_entry;
   mat_entry_t    head;
   logic          fifo_empty;
   logic          fifo_full;
   logic          push;
   logic          pop;

   // Deserializer: shift on each detected sck edge, count bits, and drop a
   // partial transfer once the link has been quiet for IDLE_CYCLES.
   always_comb begin
      col_sr_d   = col_sr_q;
      row_sr_d   = row_sr_q;
      bit_cnt_d  = bit_cnt_q;
      idle_cnt_d = idle_cnt_q;
      done       = 1'b0;
      if (sck_rise) begin
         col_sr_d   = {col_sr_q[N-2:0], data_s[1]};
         row_sr_d   = {row_sr_q[N-2:0], data_s[0]};
         idle_cnt_d = '0;
         if (bit_cnt_q == RW'(N - 1)) begin
            bit_cnt_d = '0;
            done      = 1'b1;
         end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
         end
      end else begin
         if (idle_cnt_q != IW'(IDLE_CYCLES)) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
         end else if (bit_cnt_q != '0) begin
            bit_cnt_d = '0;
         end
      end
   end

   // The completed word includes the bit shifted in on the final edge.
   always_comb begin
      push_entry     = '0;
      push_entry.row = mat_row_index(row_sr_d);
      push_entry.col = col_sr_d;
   end

   // FIFO control: a pop in the same cycle frees a slot for a push even when
   // full; a completed word with no room is dropped and flagged.
   always_comb begin
      fifo_empty = (wr_ptr_q == rd_ptr_q);
      fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
      pop        = !fifo_empty && out_ready;
      push       = done && (!fifo_full || pop);
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      overflow_d = overflow_q | (done && fifo_full && !pop);
   end

   // Control state: deserializer, counters, pointers and sticky overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         col_sr_q   <= '0;
         row_sr_q   <= '0;
         bit_cnt_q  <= '0;
         idle_cnt_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         col_sr_q   <= col_sr_d;
         row_sr_q   <= row_sr_d;
         bit_cnt_q  <= bit_cnt_d;
         idle_cnt_q <= idle_cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
      end
   end

   // FIFO storage; contents are only visible through the valid-masked head.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q[PW-1:0]] <= push_entry;
   end

   // Head outputs are forced to zero while empty so reset leaves them at 0.
   always_comb begin
      head      = fifo_mem[rd_ptr_q[PW-1:0]];
      out_valid = !fifo_empty;
      out_row   = out_valid ? head.row : '0;
      out_col   = out_valid ? head.col : '0;
   end

   assign overflow = overflow_q;

`ifdef ONEHOT_CHECK_EN
   logic row_err_q, row_err_d;

   function automatic logic is_onehot(input logic [N-1:0] w);
      return (w != '0) && ((w & (w - 1'b1)) == '0);
   endfunction

   // Sticky row-pattern check on every completed transfer; the word is
   // still pushed regardless of the outcome.
   always_comb begin
      row_err_d = row_err_q | (done && !is_onehot(row_sr_d));
   end

   // Row-error flag register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) row_err_q <= 1'b0;
      else       row_err_q <= row_err_d;
   end

   assign row_err = row_err_q;
`else
   assign row_err = 1'b0;
`endif

endmodule
